// File: rtl/tennis_pkg.sv
// Shared encodings for the LED tennis referee: FSM states, player sides and
// the ball positions that form each player's hit window.
package tennis_pkg;

  localparam logic [1:0] ST_SERVE     = 2'd0;
  localparam logic [1:0] ST_RALLY     = 2'd1;
  localparam logic [1:0] ST_POINT     = 2'd2;
  localparam logic [1:0] ST_GAME_OVER = 2'd3;

  localparam logic SIDE_RIGHT = 1'b0;
  localparam logic SIDE_LEFT  = 1'b1;

  localparam logic [15:0] BALL_RIGHT_END = 16'h0001;
  localparam logic [15:0] BALL_LEFT_END  = 16'h8000;

  // Ball position at which the given side is allowed to return.
  function automatic logic [15:0] end_of(input logic side);
    return (side == SIDE_LEFT) ? BALL_LEFT_END : BALL_RIGHT_END;
  endfunction

  // Scores stop at the win threshold instead of wrapping.
  function automatic logic [3:0] sat_inc(input logic [3:0] score, input logic [3:0] limit);
    return (score < limit) ? score + 4'd1 : score;
  endfunction

endpackage

// File: rtl/tennis_edge_detect.sv
// Rising-edge detector for a debounced button level; one-cycle pulse out.
module tennis_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  // Reset treats the button as already high, so a press held through reset
  // must be released before it can count again.
  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= 1'b1;
    end else begin
      level_q <= level_i;
    end
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/tennis_referee.sv
// Rally referee and score keeper: serves, returns, miss detection, point
// hold and win detection for the 16-LED tennis game.
module tennis_referee
  import tennis_pkg::*;
#(
  parameter int WIN_SCORE  = 7,
  parameter int POINT_HOLD = 50_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_right,
  input  logic        btn_left,
  input  logic [15:0] ball,
  output logic        right_trigger,
  output logic        left_trigger,
  output logic        ball_stop,
  output logic [3:0]  score_right,
  output logic [3:0]  score_left,
  output logic        serve_side,
  output logic        game_over,
  output logic        winner
);

  localparam int              CNT_W     = $clog2(POINT_HOLD + 1);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(POINT_HOLD - 1);
  localparam logic [3:0]      WIN_S     = 4'(WIN_SCORE);

  logic press_r, press_l;

  tennis_edge_detect u_edge_right (
    .clk     (clk),
    .reset   (reset),
    .level_i (btn_right),
    .rise_o  (press_r)
  );

  tennis_edge_detect u_edge_left (
    .clk     (clk),
    .reset   (reset),
    .level_i (btn_left),
    .rise_o  (press_l)
  );

  logic [1:0]       state_q, state_d;
  logic             expect_q, expect_d;
  logic             in_win_q, in_win_d;
  logic             locked_q, locked_d;
  logic [3:0]       score_r_q, score_r_d;
  logic [3:0]       score_l_q, score_l_d;
  logic             serve_side_q, serve_side_d;
  logic             winner_q, winner_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic             rtrig_q, rtrig_d;
  logic             ltrig_q, ltrig_d;

  logic win_open;
  logic press_exp;
  logic press_srv;

  assign win_open  = (ball == end_of(expect_q));
  assign press_exp = (expect_q == SIDE_LEFT) ? press_l : press_r;
  assign press_srv = (serve_side_q == SIDE_LEFT) ? press_l : press_r;

  always_comb begin
    state_d      = state_q;
    expect_d     = expect_q;
    in_win_d     = in_win_q;
    locked_d     = locked_q;
    score_r_d    = score_r_q;
    score_l_d    = score_l_q;
    serve_side_d = serve_side_q;
    winner_d     = winner_q;
    hold_d       = hold_q;
    rtrig_d      = 1'b0;
    ltrig_d      = 1'b0;

    case (state_q)
      ST_SERVE: begin
        if (press_srv) begin
          if (serve_side_q == SIDE_LEFT) ltrig_d = 1'b1;
          else                           rtrig_d = 1'b1;
          expect_d = ~serve_side_q;
          in_win_d = 1'b0;
          locked_d = 1'b0;
          state_d  = ST_RALLY;
        end
      end

      ST_RALLY: begin
        // An accepted return wins over a miss when the window closes the same cycle.
        if (press_exp && win_open && !locked_q) begin
          if (expect_q == SIDE_LEFT) ltrig_d = 1'b1;
          else                       rtrig_d = 1'b1;
          expect_d = ~expect_q;
          in_win_d = 1'b0;
          locked_d = 1'b0;
        end else if (in_win_q && !win_open) begin
          if (expect_q == SIDE_LEFT) score_r_d = sat_inc(score_r_q, WIN_S);
          else                       score_l_d = sat_inc(score_l_q, WIN_S);
          serve_side_d = expect_q;
          in_win_d     = 1'b0;
          locked_d     = 1'b0;
          hold_d       = '0;
          state_d      = ST_POINT;
        end else begin
          if (press_exp && !win_open) locked_d = 1'b1;
          if (win_open)               in_win_d = 1'b1;
        end
      end

      ST_POINT: begin
        if (hold_q == HOLD_LAST) begin
          hold_d = '0;
          if (score_r_q == WIN_S || score_l_q == WIN_S) begin
            state_d  = ST_GAME_OVER;
            winner_d = (score_l_q == WIN_S) ? SIDE_LEFT : SIDE_RIGHT;
          end else begin
            state_d = ST_SERVE;
          end
        end else begin
          hold_d = hold_q + CNT_W'(1);
        end
      end

      ST_GAME_OVER: begin
        state_d = ST_GAME_OVER;
      end

      default: begin
        state_d = ST_SERVE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_SERVE;
      expect_q     <= SIDE_RIGHT;
      in_win_q     <= 1'b0;
      locked_q     <= 1'b0;
      score_r_q    <= 4'd0;
      score_l_q    <= 4'd0;
      serve_side_q <= SIDE_RIGHT;
      winner_q     <= SIDE_RIGHT;
      hold_q       <= '0;
      rtrig_q      <= 1'b0;
      ltrig_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      expect_q     <= expect_d;
      in_win_q     <= in_win_d;
      locked_q     <= locked_d;
      score_r_q    <= score_r_d;
      score_l_q    <= score_l_d;
      serve_side_q <= serve_side_d;
      winner_q     <= winner_d;
      hold_q       <= hold_d;
      rtrig_q      <= rtrig_d;
      ltrig_q      <= ltrig_d;
    end
  end

  assign right_trigger = rtrig_q;
  assign left_trigger  = ltrig_q;
  assign ball_stop     = (state_q == ST_POINT) || (state_q == ST_GAME_OVER);
  assign score_right   = score_r_q;
  assign score_left    = score_l_q;
  assign serve_side    = serve_side_q;
  assign game_over     = (state_q == ST_GAME_OVER);
  assign winner        = winner_q;

endmodule

// File: tb/tb_tennis_referee.sv
// Bench for tennis_referee: directed vector table followed by randomized
// button/ball stimulus compared with a rule-level reference model.
module tb_tennis_referee;

  localparam int WIN  = 2;
  localparam int HOLD = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_right, btn_left;
  logic [15:0] ball;
  logic        right_trigger, left_trigger, ball_stop;
  logic [3:0]  score_right, score_left;
  logic        serve_side, game_over, winner;

  always #5 clk = ~clk;

  tennis_referee #(.WIN_SCORE(WIN), .POINT_HOLD(HOLD)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_right     (btn_right),
    .btn_left      (btn_left),
    .ball          (ball),
    .right_trigger (right_trigger),
    .left_trigger  (left_trigger),
    .ball_stop     (ball_stop),
    .score_right   (score_right),
    .score_left    (score_left),
    .serve_side    (serve_side),
    .game_over     (game_over),
    .winner        (winner)
  );

  int checks   = 0;
  int failures = 0;

  // Output vector: {rt, lt, stop, score_r[4], score_l[4], serve, game_over, winner}
  typedef struct {
    logic        rst;
    logic        br;
    logic        bl;
    logic [15:0] b;
    logic [13:0] exp;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic br, logic bl, logic [15:0] b,
                              logic rt, logic lt, logic stop, logic [3:0] sr,
                              logic [3:0] sl, logic srv, logic go, logic win);
    vec_t v;
    v.rst = rst; v.br = br; v.bl = bl; v.b = b;
    v.exp = {rt, lt, stop, sr, sl, srv, go, win};
    return v;
  endfunction

  function automatic logic [13:0] dut_out();
    return {right_trigger, left_trigger, ball_stop, score_right, score_left,
            serve_side, game_over, winner};
  endfunction

  // Reference model: side index 0 = right, 1 = left; phase 0 serve, 1 rally,
  // 2 point (countdown of remaining hold cycles), 3 game over.
  int m_phase, m_serve, m_expect, m_inwin, m_locked, m_hold_left, m_winner;
  int m_score[2];
  int m_trig[2];
  int m_prev[2];

  task automatic model_step(input logic rst, input logic br, input logic bl, input logic [15:0] b);
    int  press[2];
    int  open;
    int  scorer;
    if (rst) begin
      m_phase = 0; m_serve = 0; m_expect = 0; m_inwin = 0; m_locked = 0;
      m_hold_left = 0; m_winner = 0;
      m_score[0] = 0; m_score[1] = 0;
      m_trig[0] = 0; m_trig[1] = 0;
      m_prev[0] = 1; m_prev[1] = 1;
      return;
    end
    press[0] = (br && m_prev[0] == 0) ? 1 : 0;
    press[1] = (bl && m_prev[1] == 0) ? 1 : 0;
    m_prev[0] = br ? 1 : 0;
    m_prev[1] = bl ? 1 : 0;
    m_trig[0] = 0; m_trig[1] = 0;
    case (m_phase)
      0: if (press[m_serve] == 1) begin
           m_trig[m_serve] = 1;
           m_expect = 1 - m_serve;
           m_inwin = 0; m_locked = 0;
           m_phase = 1;
         end
      1: begin
           open = (m_expect == 1) ? (b == 16'h8000) : (b == 16'h0001);
           if (press[m_expect] == 1 && open != 0 && m_locked == 0) begin
             m_trig[m_expect] = 1;
             m_expect = 1 - m_expect;
             m_inwin = 0; m_locked = 0;
           end else if (m_inwin == 1 && open == 0) begin
             scorer = 1 - m_expect;
             if (m_score[scorer] < WIN) m_score[scorer] = m_score[scorer] + 1;
             m_serve = m_expect;
             m_hold_left = HOLD;
             m_inwin = 0; m_locked = 0;
             m_phase = 2;
           end else begin
             if (press[m_expect] == 1) m_locked = 1;
             if (open != 0) m_inwin = 1;
           end
         end
      2: begin
           m_hold_left = m_hold_left - 1;
           if (m_hold_left == 0) begin
             if (m_score[0] == WIN || m_score[1] == WIN) begin
               m_phase = 3;
               m_winner = (m_score[1] == WIN) ? 1 : 0;
             end else begin
               m_phase = 0;
             end
           end
         end
      default: ;
    endcase
  endtask

  function automatic logic [13:0] model_out();
    return {m_trig[0] == 1, m_trig[1] == 1, m_phase >= 2, 4'(m_score[0]), 4'(m_score[1]),
            m_serve == 1, m_phase == 3, m_winner == 1};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step(reset, btn_right, btn_left, ball);
    @(negedge clk);
  endtask

  task automatic check(input string name, input int idx, input logic [13:0] act, input logic [13:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] got {rt,lt,stop,sr,sl,srv,go,win}=%b want=%b", name, idx, act, exp);
    end
  endtask

  initial begin
    //             rst br bl ball      rt lt st sr sl srv go win
    tbl.push_back(mk(1, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0)); // reset
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0)); // wrong server
    tbl.push_back(mk(0, 1, 1, 16'h0001, 1, 0, 0, 0, 0, 0, 0, 0)); // right serves
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0100, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h8000, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h8000, 0, 1, 0, 0, 0, 0, 0, 0)); // left returns
    tbl.push_back(mk(0, 0, 0, 16'h4000, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0002, 0, 0, 1, 0, 1, 0, 0, 0)); // right misses
    tbl.push_back(mk(0, 1, 0, 16'h0001, 0, 0, 1, 0, 1, 0, 0, 0)); // press in POINT
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 1, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 0, 0, 1, 0, 0, 0)); // back to SERVE
    tbl.push_back(mk(0, 1, 0, 16'h0001, 1, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h0100, 0, 0, 0, 0, 1, 0, 0, 0)); // early swing
    tbl.push_back(mk(0, 0, 0, 16'h8000, 0, 0, 0, 0, 1, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h8000, 0, 0, 0, 0, 1, 0, 0, 0)); // locked out
    tbl.push_back(mk(0, 0, 0, 16'h4000, 0, 0, 1, 1, 1, 1, 0, 0)); // left misses
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 1, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 1, 16'h8000, 0, 1, 0, 1, 1, 1, 0, 0)); // left serves
    tbl.push_back(mk(0, 0, 0, 16'h8000, 0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 1, 1, 16'h0001, 1, 0, 0, 1, 1, 1, 0, 0)); // both press, right expected
    tbl.push_back(mk(0, 0, 0, 16'h0002, 0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h8000, 0, 0, 0, 1, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h4000, 0, 0, 1, 2, 1, 1, 0, 0)); // right reaches WIN
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 1, 2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 1, 2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 1, 2, 1, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 1, 2, 1, 1, 1, 0)); // game over
    tbl.push_back(mk(0, 1, 0, 16'h0001, 0, 0, 1, 2, 1, 1, 1, 0)); // ignored
    tbl.push_back(mk(1, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0)); // reset clears
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0001, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h8000, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 1, 1, 0, 1, 0, 0)); // miss -> POINT
    tbl.push_back(mk(1, 1, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0)); // reset in POINT
    tbl.push_back(mk(0, 1, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0)); // held through reset
    tbl.push_back(mk(0, 0, 0, 16'h0001, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 16'h0001, 1, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 16'h8000, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 16'h8000, 0, 1, 0, 0, 0, 0, 0, 0)); // both press, left expected

    reset = 1'b1; btn_right = 1'b0; btn_left = 1'b0; ball = 16'h0001;

    for (int i = 0; i < tbl.size(); i++) begin
      reset     = tbl[i].rst;
      btn_right = tbl[i].br;
      btn_left  = tbl[i].bl;
      ball      = tbl[i].b;
      tick();
      check("vec", i, dut_out(), tbl[i].exp);
    end

    reset = 1'b1; btn_right = 1'b0; btn_left = 1'b0;
    tick();
    check("rand_reset", 0, dut_out(), model_out());

    for (int n = 0; n < 5000; n++) begin
      if (m_phase == 3) reset = ($urandom_range(0, 7) == 0);
      else              reset = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) == 0) btn_right = ~btn_right;
      if ($urandom_range(0, 3) == 0) btn_left  = ~btn_left;
      case ($urandom_range(0, 9))
        0, 1, 2, 3: ball = 16'h0001;
        4, 5, 6, 7: ball = 16'h8000;
        default:    ball = 16'h0001 << $urandom_range(0, 15);
      endcase
      tick();
      check("rand", n, dut_out(), model_out());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tennis_referee.md
# tennis_referee

Rally referee and score keeper for the LED tennis game. It watches the one-hot 16-LED ball position and the two debounced player buttons. It issues one-cycle `right_trigger`/`left_trigger` serve and return pulses to the ball mover, detects misses, and keeps each player's score up to a win threshold. It sits between the debouncers and the ball mover, and drives the score display.

## Interface
- `WIN_SCORE`, default 7: points needed to win; legal range 1..15.
- `POINT_HOLD`, default 50_000_000: cycles spent in POINT after a miss, with the ball mover stopped.
- `clk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock clk.
- `btn_right` in 1: debounced right-player button level.
- `btn_left` in 1: debounced left-player button level.
- `ball` in 16: one-hot ball position; `ball[0]` is the right end, `ball[15]` is the left end.
- `right_trigger` out 1: one-cycle pulse that serves or returns from the right (ball to LED0, moving left).
- `left_trigger` out 1: one-cycle pulse that serves or returns from the left (ball to LED15, moving right).
- `ball_stop` out 1: level; the top ORs it into the ball mover's reset.
- `score_right` out 4: right player's points.
- `score_left` out 4: left player's points.
- `serve_side` out 1: side that serves next; 0 = right, 1 = left.
- `game_over` out 1: high once either score equals `WIN_SCORE`.
- `winner` out 1: valid while `game_over` is high; 0 = right, 1 = left.

## Operation
- States: SERVE, RALLY, POINT, GAME_OVER. Reset enters SERVE.
- Button presses are rising edges of the button level, found against a registered copy of that level.
- SERVE:
  - A press by the `serve_side` player pulses the matching trigger and enters RALLY.
  - `expect` is set to the opposite side. Presses by the other player are ignored.
  - `ball` is ignored in this state.
- RALLY tracks three registers: `expect` (side the ball is heading to), `in_win` and `locked`.
- Hit window: `ball == 16'h8000` when `expect` = left, or `ball == 16'h0001` when `expect` = right.
- Press by the `expect` player:
  - While the window is open and `locked` = 0: pulse that player's trigger, flip `expect`, clear `in_win` and `locked`.
  - While the window is closed: this is an early swing. Set `locked`; the return can no longer succeed for this approach.
  - While the window is open and `locked` = 1: ignored.
- A press by the non-`expect` player is always ignored.
- `in_win` is set on any cycle the window is open.
- Miss: `in_win` = 1 and the window is now closed with no accepted return. Then:
  - The non-`expect` player's score increments.
  - `serve_side` is set to the `expect` side (the player who missed serves).
  - The block enters POINT.
- If both players press in the same cycle, only the `expect` player's press is evaluated.
- A return accepted in the same cycle the window closes counts as a hit, not a miss.
- POINT:
  - `ball_stop` = 1 for exactly `POINT_HOLD` cycles.
  - Then the block enters GAME_OVER if either score equals `WIN_SCORE`, otherwise SERVE.
  - All presses are ignored.
- GAME_OVER: `ball_stop` = 1, `game_over` = 1, `winner` latched. Only `reset` leaves this state.
- Scores saturate at `WIN_SCORE` and never wrap.

## Timing
- Reset values: both triggers 0, `ball_stop` 0, both scores 0, `serve_side` 0, `game_over` 0, `winner` 0, `expect`/`in_win`/`locked` 0, hold counter 0.
- A trigger pulses high for exactly one cycle, on the cycle after the button rising edge is sampled.
- Edge-detector state is also reset, so a button held through reset does not fire.
- Miss detection:
  - The score update and the POINT entry are registered on the cycle after the first cycle with the window closed.
  - `ball_stop` goes high on that same edge.
- Hold counter width is `$clog2(POINT_HOLD+1)`. It counts 0..`POINT_HOLD`-1, and SERVE or GAME_OVER is entered on the next edge.
- `reset` mid-rally or mid-POINT takes effect on the next edge. No trigger is emitted on that edge.

## Structure
- Package `tennis_pkg`:
  - state encoding (SERVE, RALLY, POINT, GAME_OVER);
  - side encoding `SIDE_RIGHT` = 0, `SIDE_LEFT` = 1;
  - constants `BALL_RIGHT_END` = 16'h0001, `BALL_LEFT_END` = 16'h8000.
- Sub-module `tennis_edge_detect`, instantiated twice: takes clk, reset and level; outputs a one-cycle rising-edge pulse.
- Top: FSM, window/lock logic, score registers, hold counter.

## Test plan
- Serve: reset, press `btn_right` → `right_trigger` high for 1 cycle, state RALLY, `expect` = left; `btn_left` pressed during SERVE → no trigger.
- Return: in RALLY with `expect` = left, drive `ball` = 16'h8000, press `btn_left` → `left_trigger` pulses once, `expect` = right, scores unchanged.
- Miss: `ball` = 16'h8000 for 3 cycles, then 16'h4000 with no press → `score_right` = 1, `serve_side` = 1, `ball_stop` high for exactly `POINT_HOLD` (set to 4) cycles, then SERVE.
- Early swing: `expect` = left, press `btn_left` while `ball` = 16'h0100, then press again at 16'h8000 → no trigger; miss scored to right on window exit.
- Win: `WIN_SCORE` = 2, two left misses → `score_right` = 2, `game_over` = 1, `winner` = 0, `ball_stop` stays 1; further presses ignored; `reset` clears all outputs.
- Simultaneous/reset: both buttons pressed at 16'h8000 with `expect` = left → only `left_trigger`; assert `reset` during POINT → next cycle all outputs at reset values.
